// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// loaded byte-wise by the debug unit, and the IF/ID register feeding decode.
module if_fetch_stage #(
  parameter int                 NB_ADDR     = 32,
  parameter int                 NB_INST     = 32,
  parameter int                 NB_BYTE     = 8,
  parameter int                 NB_MEM_ADDR = 8,
  parameter logic [NB_INST-1:0] HALT_CODE   = 32'hFFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_pc_src,
  input  logic [NB_ADDR-1:0]     i_target_addr,
  input  logic                   i_load_valid,
  input  logic [NB_BYTE-1:0]     i_load_byte,
  output logic [NB_ADDR-1:0]     o_pc,
  output logic [NB_INST-1:0]     o_instruction,
  output logic                   o_halt,
  output logic [NB_ADDR-1:0]     o_pc_debug,
  output logic [NB_MEM_ADDR:0]   o_load_words
);

  localparam int DEPTH   = 2 ** NB_MEM_ADDR;
  localparam int BPW     = NB_INST / NB_BYTE;
  localparam int NB_BCNT = $clog2(BPW);

  typedef enum logic [0:0] {
    ST_RUN,
    ST_HALTED
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [NB_INST-1:0]     mem [DEPTH];

  state_t                 state_reg;
  state_t                 state_next;

  logic [NB_ADDR-1:0]     pc_reg;
  logic [NB_ADDR-1:0]     pc_next;
  logic [NB_ADDR-1:0]     pc_plus4;
  logic [NB_ADDR-1:0]     if_pc_reg;
  logic [NB_INST-1:0]     if_inst_reg;

  logic [NB_INST-1:0]     asm_reg;
  logic [NB_INST-1:0]     asm_next;
  logic [NB_BCNT-1:0]     byte_cnt_reg;
  logic [NB_MEM_ADDR-1:0] load_ptr_reg;
  logic [NB_MEM_ADDR:0]   load_words_reg;

  // ---------------------------------------------------------------------------
  // Fetch datapath
  // ---------------------------------------------------------------------------
  logic [NB_MEM_ADDR-1:0] fetch_idx;
  logic [NB_INST-1:0]     fetch_word;
  logic                   fetch_is_halt;

  // Low two PC bits select a byte inside the word and are not used for fetch.
  assign fetch_idx     = pc_reg[NB_MEM_ADDR+1:2];
  assign fetch_word    = mem[fetch_idx];
  assign fetch_is_halt = (fetch_word == HALT_CODE);
  assign pc_plus4      = pc_reg + NB_ADDR'(4);
  assign pc_next       = i_pc_src ? i_target_addr : pc_plus4;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (i_enable && !i_stall && !i_flush && fetch_is_halt) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: control strobes
  // ---------------------------------------------------------------------------
  logic pc_we;
  logic ifid_we;
  logic ifid_nop;

  always_comb begin
    pc_we    = 1'b0;
    ifid_we  = 1'b0;
    ifid_nop = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (i_enable) begin
          if (i_flush) begin
            // Flush overrides stall for IF/ID and discards a fetched HALT.
            ifid_we  = 1'b1;
            ifid_nop = 1'b1;
            pc_we    = !i_stall;
          end else if (!i_stall) begin
            ifid_we = 1'b1;
            pc_we   = !fetch_is_halt;
          end
        end
      end
      default: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        ifid_nop = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC and IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc_reg      <= '0;
      if_pc_reg   <= '0;
      if_inst_reg <= '0;
    end else begin
      if (pc_we) begin
        pc_reg <= pc_next;
      end
      if (ifid_we) begin
        if_inst_reg <= ifid_nop ? '0 : fetch_word;
        if_pc_reg   <= ifid_nop ? '0 : pc_plus4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Program loader
  // ---------------------------------------------------------------------------
  logic load_accept;
  logic load_last;

  assign load_accept = i_load_valid && !i_enable;
  assign load_last   = load_accept && (byte_cnt_reg == NB_BCNT'(BPW - 1));
  assign asm_next    = {asm_reg[NB_INST-NB_BYTE-1:0], i_load_byte};

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      asm_reg        <= '0;
      byte_cnt_reg   <= '0;
      load_ptr_reg   <= '0;
      load_words_reg <= '0;
    end else if (load_accept) begin
      asm_reg      <= asm_next;
      byte_cnt_reg <= load_last ? '0 : byte_cnt_reg + NB_BCNT'(1);
      if (load_last) begin
        load_ptr_reg <= load_ptr_reg + NB_MEM_ADDR'(1);
        if (load_words_reg != (NB_MEM_ADDR+1)'(DEPTH)) begin
          load_words_reg <= load_words_reg + (NB_MEM_ADDR+1)'(1);
        end
      end
    end
  end

  // Memory has no reset; a reset on the final-byte edge drops the word.
  always_ff @(posedge i_clk) begin
    if (i_reset && load_last) begin
      mem[load_ptr_reg] <= asm_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_pc          = if_pc_reg;
  assign o_instruction = if_inst_reg;
  assign o_halt        = (state_reg == ST_HALTED);
  assign o_pc_debug    = pc_reg;
  assign o_load_words  = load_words_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed program scenarios followed by
// randomized run/stall/flush/redirect/load traffic against a behavioural model.
module tb_if_fetch_stage;

  localparam int          MA    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic        stall;
  logic        flush;
  logic        pc_src;
  logic [31:0] tgt;
  logic        lv;
  logic [7:0]  lb;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_halt;
  logic [31:0] o_pc_debug;
  logic [MA:0] o_load_words;

  if_fetch_stage #(
    .NB_MEM_ADDR(MA)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_enable      (en),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_pc_src      (pc_src),
    .i_target_addr (tgt),
    .i_load_valid  (lv),
    .i_load_byte   (lb),
    .o_pc          (o_pc),
    .o_instruction (o_inst),
    .o_halt        (o_halt),
    .o_pc_debug    (o_pc_debug),
    .o_load_words  (o_load_words)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_opc, m_inst, m_asm;
  bit          m_halted;
  int          m_words, m_ptr, m_nbytes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    logic [31:0] w;
    logic [31:0] nw;
    if (!rst_n) begin
      m_pc = 0; m_opc = 0; m_inst = 0; m_halted = 0;
      m_words = 0; m_ptr = 0; m_nbytes = 0; m_asm = 0;
      return;
    end
    if (!en) begin
      if (lv) begin
        nw = {m_asm[23:0], lb};
        m_asm = nw;
        m_nbytes++;
        if (m_nbytes == 4) begin
          m_mem[m_ptr] = nw;
          m_ptr = (m_ptr + 1) % DEPTH;
          m_nbytes = 0;
          if (m_words < DEPTH) m_words++;
        end
      end
      return;
    end
    if (m_halted) return;
    w = m_mem[(m_pc >> 2) % DEPTH];
    if (flush) begin
      m_inst = 0;
      m_opc  = 0;
      if (!stall) m_pc = pc_src ? tgt : m_pc + 4;
    end else if (!stall) begin
      m_inst = w;
      m_opc  = m_pc + 4;
      if (w == HALT) m_halted = 1;
      else           m_pc = pc_src ? tgt : m_pc + 4;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("o_pc", o_pc, m_opc);
    check("o_instruction", o_inst, m_inst);
    check("o_halt", {31'b0, o_halt}, {31'b0, m_halted});
    check("o_pc_debug", o_pc_debug, m_pc);
    check("o_load_words", 32'(o_load_words), 32'(m_words));
  endtask

  task automatic idle();
    rst_n = 1; en = 0; stall = 0; flush = 0; pc_src = 0; tgt = 0; lv = 0; lb = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      lv = 1;
      lb = w[31-8*i -: 8];
      tick();
    end
    lv = 0;
    $display("load word %h -> load_words=%0d", w, o_load_words);
  endtask

  initial begin
    idle();
    rst_n = 0;
    do_reset();
    check("reset_inst", o_inst, 32'h0);
    check("reset_pc", o_pc, 32'h0);
    check("reset_load_words", 32'(o_load_words), 32'd0);

    // Load and run
    load_word(32'h0001_0203);
    load_word(32'h2008_0005);
    load_word(HALT);
    check("load_words_3", 32'(o_load_words), 32'd3);
    en = 1;
    tick(); check("run_inst0", o_inst, 32'h0001_0203); check("run_pc0", o_pc, 32'd4);
    tick(); check("run_inst1", o_inst, 32'h2008_0005); check("run_pc1", o_pc, 32'd8);
    tick(); check("run_halt_inst", o_inst, HALT); check("run_halt", {31'b0, o_halt}, 32'd1);
    pc_src = 1; tgt = 32'h40;
    tick(); tick();
    pc_src = 0;
    check("halt_pc_debug", o_pc_debug, 32'd8);
    $display("scenario load_and_run done");

    // Stall
    do_reset();
    tick();
    stall = 1; pc_src = 1; tgt = 32'h0;
    tick(); check("stall1_inst", o_inst, 32'h0001_0203); check("stall1_pc_dbg", o_pc_debug, 32'd4);
    tick(); check("stall2_inst", o_inst, 32'h0001_0203); check("stall2_pc_dbg", o_pc_debug, 32'd4);
    stall = 0; pc_src = 0;
    tick(); check("after_stall_inst", o_inst, 32'h2008_0005); check("after_stall_pc", o_pc, 32'd8);
    $display("scenario stall done");

    // Redirect and flush at pc=8 (also flushes the HALT fetched there)
    pc_src = 1; tgt = 32'h0; flush = 1;
    tick(); check("flush_inst", o_inst, 32'h0); check("flush_pc", o_pc, 32'h0);
    check("flush_halt", {31'b0, o_halt}, 32'd0); check("flush_pc_dbg", o_pc_debug, 32'h0);
    pc_src = 0; flush = 0;
    tick(); check("redir_inst", o_inst, 32'h0001_0203); check("redir_pc", o_pc, 32'd4);
    $display("scenario redirect_flush done");

    // Flush with stall over HALT: NOP in IF/ID, pc holds, stays RUN
    tick();
    flush = 1; stall = 1;
    tick(); check("fs_inst", o_inst, 32'h0); check("fs_halt", {31'b0, o_halt}, 32'd0);
    check("fs_pc_dbg", o_pc_debug, 32'd8);
    flush = 0; stall = 0;
    tick(); check("fs_then_halt", {31'b0, o_halt}, 32'd1);
    $display("scenario flush_over_halt done");

    // Load rules and reset mid-load
    do_reset();
    en = 1; stall = 1;
    for (int i = 0; i < 3; i++) begin lv = 1; lb = 8'hEE; tick(); end
    lv = 0; stall = 0;
    check("load_ignored", 32'(o_load_words), 32'd0);
    en = 0;
    for (int i = 0; i < 2; i++) begin lv = 1; lb = 8'hAA + 8'(i); tick(); end
    lv = 0;
    do_reset();
    check("rst_all_inst", o_inst, 32'h0); check("rst_all_dbg", o_pc_debug, 32'h0);
    load_word(32'h1234_5678);
    en = 1;
    tick(); check("reload_w0", o_inst, 32'h1234_5678);
    tick(); check("reload_w1", o_inst, 32'h2008_0005);
    $display("scenario load_rules done");

    // Wrap: 5 words into a 4-word memory
    en = 0;
    do_reset();
    for (int i = 1; i <= 5; i++) load_word({4{8'(i * 8'h11)}});
    check("wrap_words_sat", 32'(o_load_words), 32'd4);
    en = 1;
    tick(); check("wrap_w0", o_inst, 32'h5555_5555);
    tick(); check("wrap_w1", o_inst, 32'h2222_2222);
    $display("scenario wrap done");

    // Randomized traffic
    idle();
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      load_word(($urandom_range(0, 5) == 0) ? HALT : $urandom);
    for (int c = 0; c < 3000; c++) begin
      rst_n  = !(($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 9) == 0));
      en     = ($urandom_range(0, 99) < 85);
      stall  = ($urandom_range(0, 99) < 20);
      flush  = ($urandom_range(0, 99) < 10);
      pc_src = ($urandom_range(0, 99) < 15);
      tgt    = $urandom;
      lv     = ($urandom_range(0, 99) < 60);
      lb     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      tick();
    end
    idle();
    $display("scenario random done: 3000 cycles");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
